// File: rtl/cmd_deframer.sv
// Command frame receiver: hunts for 0xA5, collects op/len/payload/checksum,
// publishes good frames and answers each frame with a single ACK or NAK byte.
module cmd_deframer #(
  parameter int MAXLEN  = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  newrxstrobe,
  input  logic [7:0]            rxbyte,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_op,
  output logic [3:0]            cmd_len,
  output logic [8*MAXLEN-1:0]   cmd_data,
  output logic                  xmit,
  output logic [7:0]            txchar,
  output logic                  frame_err
);

  localparam int            IW       = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TMO      = IW'(TIMEOUT);
  localparam logic [7:0]    HDR      = 8'hA5;
  localparam logic [7:0]    ACK      = 8'h06;
  localparam logic [7:0]    NAK      = 8'h15;
  localparam logic [7:0]    MAXLEN_B = 8'(MAXLEN);

  typedef enum logic [2:0] {
    HUNT,
    OP,
    LEN,
    DATA,
    CHK
  } state_t;

  state_t              state;
  logic [7:0]          op_r;
  logic [3:0]          len_r;
  logic [3:0]          count;
  logic [7:0]          sum;
  logic [8*MAXLEN-1:0] pbuf;
  logic [IW-1:0]       idle_cnt;

  // Whole deframer in one register block: strobes default low each cycle, a
  // received byte always wins over an expiring idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      op_r      <= '0;
      len_r     <= '0;
      count     <= '0;
      sum       <= '0;
      pbuf      <= '0;
      idle_cnt  <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_len   <= '0;
      cmd_data  <= '0;
      xmit      <= 1'b0;
      txchar    <= '0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      xmit      <= 1'b0;
      frame_err <= 1'b0;
      if (newrxstrobe) begin
        idle_cnt <= '0;
        unique case (state)
          HUNT: begin
            if (rxbyte == HDR) state <= OP;
          end
          OP: begin
            op_r  <= rxbyte;
            sum   <= rxbyte;
            pbuf  <= '0;
            count <= '0;
            state <= LEN;
          end
          LEN: begin
            if (rxbyte > MAXLEN_B) begin
              frame_err <= 1'b1;
              xmit      <= 1'b1;
              txchar    <= NAK;
              state     <= HUNT;
            end else begin
              len_r <= rxbyte[3:0];
              sum   <= sum + rxbyte;
              state <= (rxbyte == 8'd0) ? CHK : DATA;
            end
          end
          DATA: begin
            for (int i = 0; i < MAXLEN; i++) begin
              if (count == 4'(i)) pbuf[8*i +: 8] <= rxbyte;
            end
            sum   <= sum + rxbyte;
            count <= count + 4'd1;
            if (count == len_r - 4'd1) state <= CHK;
          end
          CHK: begin
            xmit  <= 1'b1;
            state <= HUNT;
            if (rxbyte == sum) begin
              cmd_valid <= 1'b1;
              txchar    <= ACK;
              cmd_op    <= op_r;
              cmd_len   <= len_r;
              cmd_data  <= pbuf;
            end else begin
              frame_err <= 1'b1;
              txchar    <= NAK;
            end
          end
          default: state <= HUNT;
        endcase
      end else if (state != HUNT) begin
        // A stalled partial frame is dropped silently apart from the error pulse.
        if (idle_cnt == TMO) begin
          state     <= HUNT;
          frame_err <= 1'b1;
          idle_cnt  <= '0;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_deframer.sv
// Self-checking bench for cmd_deframer: table of frames plus hand-written
// timeout and reset sequences, all checked through an expected-event queue.
module tb_cmd_deframer;

  localparam int MAXLEN  = 8;
  localparam int TIMEOUT = 5000;
  localparam int K_ACK   = 0;
  localparam int K_NAK   = 1;
  localparam int K_TMO   = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                newrxstrobe;
  logic [7:0]          rxbyte;
  logic                cmd_valid;
  logic [7:0]          cmd_op;
  logic [3:0]          cmd_len;
  logic [8*MAXLEN-1:0] cmd_data;
  logic                xmit;
  logic [7:0]          txchar;
  logic                frame_err;

  cmd_deframer #(.MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .newrxstrobe(newrxstrobe),
    .rxbyte(rxbyte),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_len(cmd_len),
    .cmd_data(cmd_data),
    .xmit(xmit),
    .txchar(txchar),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           n;
    logic [127:0] seq;
    int           kind;
    logic [7:0]   op;
    logic [3:0]   len;
    logic [63:0]  data;
  } vec_t;

  typedef struct {
    int          due;
    bit          valid;
    bit          err;
    bit          xm;
    logic [7:0]  tx;
    logic [7:0]  op;
    logic [3:0]  len;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          prev_xmit = 1'b0;
  logic [7:0]  last_op = '0;
  logic [3:0]  last_len = '0;
  logic [63:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected reply is queued one edge ahead of the byte that triggers it.
  task automatic push_exp(input int kind, input logic [7:0] op, input logic [3:0] len,
                          input logic [63:0] data);
    exp_t e;
    e.due = (kind == K_TMO) ? cyc + TIMEOUT + 2 : cyc + 1;
    if (kind == K_ACK) begin
      last_op   = op;
      last_len  = len;
      last_data = data;
    end
    e.valid = (kind == K_ACK);
    e.err   = (kind != K_ACK);
    e.xm    = (kind != K_TMO);
    e.tx    = (kind == K_ACK) ? 8'h06 : 8'h15;
    e.op    = last_op;
    e.len   = last_len;
    e.data  = last_data;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    newrxstrobe = 1'b1;
    rxbyte      = b;
    @(posedge clk);
    #1 newrxstrobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    logic [127:0] s;
    for (int j = 0; j < v.n; j++) begin
      s = v.seq >> (8 * (v.n - 1 - j));
      if (j == v.n - 1) push_exp(v.kind, v.op, v.len, v.data);
      apply_stimulus(s[7:0]);
    end
  endtask

  // Every output event must match the head of the queue, on the exact cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_event: got none expected event due at cycle %0d (now %0d)",
                 sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (cmd_valid || xmit || frame_err) begin
        if (xmit) check_output("xmit_not_consecutive", 64'(prev_xmit), 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got valid=%0b xmit=%0b err=%0b expected none (cycle %0d)",
                   cmd_valid, xmit, frame_err, cyc);
        end else begin
          e = sb.pop_front();
          check_output("latency_cycle", 64'(cyc), 64'(e.due));
          check_output("cmd_valid", 64'(cmd_valid), 64'(e.valid));
          check_output("frame_err", 64'(frame_err), 64'(e.err));
          check_output("xmit", 64'(xmit), 64'(e.xm));
          if (e.xm) check_output("txchar", 64'(txchar), 64'(e.tx));
          check_output("cmd_op", 64'(cmd_op), 64'(e.op));
          check_output("cmd_len", 64'(cmd_len), 64'(e.len));
          check_output("cmd_data", cmd_data, e.data);
        end
      end
      prev_xmit = xmit;
    end else begin
      prev_xmit = 1'b0;
    end
  end

  vec_t tbl[9];

  initial begin
    tbl[0] = '{6, 128'hA5_10_02_11_22_45, K_ACK, 8'h10, 4'd2, 64'h2211};
    tbl[1] = '{6, 128'hA5_10_02_11_22_46, K_NAK, 8'h00, 4'd0, 64'h0};
    tbl[2] = '{3, 128'hA5_01_09, K_NAK, 8'h00, 4'd0, 64'h0};
    tbl[3] = '{4, 128'hA5_20_00_20, K_ACK, 8'h20, 4'd0, 64'h0};
    tbl[4] = '{6, 128'hA5_FF_02_FF_FF_FF, K_ACK, 8'hFF, 4'd2, 64'hFFFF};
    tbl[5] = '{7, 128'h00_33_A5_30_01_A5_D6, K_ACK, 8'h30, 4'd1, 64'hA5};
    tbl[6] = '{12, 128'hA5_07_08_01_02_03_04_05_06_07_08_33, K_ACK, 8'h07, 4'd8,
               64'h0807060504030201};
    tbl[7] = '{4, 128'hA5_A5_00_A5, K_ACK, 8'hA5, 4'd0, 64'h0};
    tbl[8] = '{4, 128'hA5_20_00_21, K_NAK, 8'h00, 4'd0, 64'h0};

    rst_n       = 1'b0;
    newrxstrobe = 1'b0;
    rxbyte      = 8'h00;
    repeat (3) @(negedge clk);
    check_output("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    check_output("reset_xmit", 64'(xmit), 64'd0);
    check_output("reset_frame_err", 64'(frame_err), 64'd0);
    check_output("reset_txchar", 64'(txchar), 64'd0);
    check_output("reset_cmd_op", 64'(cmd_op), 64'd0);
    check_output("reset_cmd_len", 64'(cmd_len), 64'd0);
    check_output("reset_cmd_data", cmd_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frames run back to back: each header follows the previous chk directly.
    for (int i = 0; i < 9; i++) send_frame(tbl[i]);
    idle(3);

    // A byte landing exactly on the expiry cycle keeps the frame alive.
    apply_stimulus(8'hA5);
    apply_stimulus(8'h10);
    idle(TIMEOUT);
    apply_stimulus(8'h00);
    push_exp(K_ACK, 8'h10, 4'd0, 64'h0);
    apply_stimulus(8'h10);
    idle(3);

    // Genuine timeout, then a fresh frame proves the FSM is back in HUNT.
    apply_stimulus(8'hA5);
    push_exp(K_TMO, 8'h00, 4'd0, 64'h0);
    apply_stimulus(8'h10);
    idle(TIMEOUT + 10);
    send_frame(tbl[3]);
    idle(3);

    // Reset in the middle of a payload.
    apply_stimulus(8'hA5);
    apply_stimulus(8'h10);
    apply_stimulus(8'h02);
    apply_stimulus(8'h11);
    rst_n = 1'b0;
    #1;
    check_output("midreset_cmd_op", 64'(cmd_op), 64'd0);
    check_output("midreset_cmd_len", 64'(cmd_len), 64'd0);
    check_output("midreset_cmd_data", cmd_data, 64'd0);
    check_output("midreset_txchar", 64'(txchar), 64'd0);
    last_op   = '0;
    last_len  = '0;
    last_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    apply_stimulus(8'hA5);
    apply_stimulus(8'h05);
    apply_stimulus(8'h00);
    push_exp(K_ACK, 8'h05, 4'd0, 64'h0);
    apply_stimulus(8'h05);
    idle(6);

    check_output("queue_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_deframer.md
CMD_DEFRAMER -- requirements
Module: cmd_deframer

Interface
REQ-001 Parameter MAXLEN, default 8: maximum payload bytes per frame (1..15).
REQ-002 Parameter TIMEOUT, default 5000: idle clk cycles between bytes before a partial frame is abandoned.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 newrxstrobe  in  1  one-cycle strobe from the serial receiver; rxbyte valid while high.
REQ-006 rxbyte  in  8  received byte.
REQ-007 cmd_valid  out  1  one-cycle strobe: a complete frame with correct checksum was received.
REQ-008 cmd_op  out  8  opcode of the last good frame.
REQ-009 cmd_len  out  4  payload length of the last good frame.
REQ-010 cmd_data  out  8*MAXLEN  payload of the last good frame; byte i at bits [8i+7:8i].
REQ-011 xmit  out  1  one-cycle strobe to the serial transmitter FIFO.
REQ-012 txchar  out  8  reply byte, valid while xmit high.
REQ-013 frame_err  out  1  one-cycle strobe on any rejected frame.

Function
REQ-014 Frame format SHALL be: header 0xA5, op, len, len payload bytes, chk.
REQ-015 chk SHALL equal (op + len + sum of payload) mod 256, 8-bit wraparound.
REQ-016 States SHALL be HUNT, OP, LEN, DATA, CHK; state advances only on newrxstrobe, except on timeout.
REQ-017 HUNT: byte 0xA5 -> OP; any other byte ignored silently, no outputs.
REQ-018 OP: store op, clear running sum and payload buffer to zero, sum <= op -> LEN.
REQ-019 LEN: len in 0..MAXLEN -> store, sum += len, go to DATA if len>0 else CHK.
REQ-020 LEN: len > MAXLEN -> frame_err pulse, xmit pulse with txchar 0x15 (NAK), -> HUNT.
REQ-021 DATA: store byte at index count, sum += byte, count++; after len-th byte -> CHK.
REQ-022 CHK match: in the next cycle cmd_valid=1, cmd_op/cmd_len/cmd_data updated the same cycle, xmit=1 with txchar 0x06 (ACK); -> HUNT.
REQ-023 CHK mismatch: next cycle frame_err=1, xmit=1 with txchar 0x15; cmd_* unchanged; -> HUNT.
REQ-024 Latency from the newrxstrobe of the final byte to cmd_valid/xmit SHALL be exactly 1 clk.
REQ-025 cmd_op, cmd_len and cmd_data SHALL hold their values until the next cmd_valid.
REQ-026 Unused payload slots above cmd_len SHALL read zero in cmd_data.
REQ-027 0xA5 received in any state other than HUNT SHALL be treated as ordinary data, not resync.
REQ-028 An idle counter SHALL reset on every newrxstrobe and count while state != HUNT.
REQ-029 At idle count == TIMEOUT: -> HUNT, frame_err pulse, no xmit, buffers not published.
REQ-030 newrxstrobe in the same cycle the timeout expires: the byte is processed and the timeout is suppressed.
REQ-031 xmit SHALL never be high for two consecutive cycles; at most one reply byte per frame.
REQ-032 Back-to-back frames, with the next header arriving the cycle after chk, SHALL be accepted.

Reset
REQ-033 rst_n low SHALL force state HUNT and clear the idle counter, sum and count immediately.
REQ-034 During reset, cmd_valid, xmit, frame_err, txchar, cmd_op, cmd_len and cmd_data SHALL all be 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; no reply byte is emitted after release.

Verification
REQ-036 A5 10 02 11 22 45 -> cmd_valid 1 clk after last strobe, cmd_op=0x10, cmd_len=2, cmd_data[15:0]=0x2211, xmit with txchar=0x06.
REQ-037 A5 10 02 11 22 46 -> frame_err and xmit with txchar=0x15; cmd_* retain previous values; no cmd_valid.
REQ-038 A5 01 09 (MAXLEN=8) -> NAK 0x15 and frame_err after the len byte; a following valid A5 20 00 20 -> ACK, cmd_op=0x20, cmd_len=0.
REQ-039 A5 FF 02 FF FF FF (sum wraps to 0xFF) -> accepted; then A5 10, idle TIMEOUT cycles -> frame_err, no xmit, state HUNT.
REQ-040 Bytes 00 33 A5 30 01 A5 D6 -> leading bytes ignored, payload 0xA5 accepted as data, cmd_valid with cmd_data[7:0]=0xA5.
REQ-041 Assert rst_n low after A5 10 02 11, release, send A5 05 00 05 -> exactly one ACK, cmd_op=0x05.
